mem_access_ctrl: RTL and testbench

- Initiator-side controller that drives the 512 x 32 synchronous data RAM on behalf of the datapath (MAR/MDR side).
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences the RAM read/write strobes and waits out the RAM read latency.
- Captures read data and returns a single-cycle completion pulse to the control unit.

---
 rtl/mem_access_ctrl.sv | 115 +++++++++++
 tb/tb_mem_access_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the synchronous data RAM: accepts one read/write
// request at a time, sequences the RAM strobes, waits out read latency, returns a done pulse.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_done,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    CAPTURE,
    DONE
  } state_e;

  localparam int unsigned CNT_W = 3;
  // WAIT spans READ_LAT-1 cycles, so the counter starts at READ_LAT-2 and exits at 0
  localparam logic [CNT_W-1:0] CNT_LOAD = (READ_LAT >= 2) ? CNT_W'(READ_LAT - 2) : '0;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          mar_d   = req_addr;
          mdr_d   = req_wdata;
          we_d    = req_we;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (we_q) begin
          state_d = DONE;
        end else if (READ_LAT == 1) begin
          state_d = CAPTURE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        rdata_d = ram_data_out;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_done   = (state_q == DONE);
  assign ram_write   = (state_q == STROBE) &&  we_q;
  assign ram_read    = (state_q == STROBE) && !we_q;
  assign ram_address = mar_q;
  assign ram_data_in = mdr_q;
  assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: two controllers (READ_LAT=1 and READ_LAT=3) each driving its own RAM model,
// sharing request fields but with separate valids so they can be exercised together or alone.
module tb_mem_access_ctrl;

  logic        clk;
  logic        clear;
  logic        valid1, valid3;
  logic        we;
  logic [8:0]  addr;
  logic [31:0] wdata;

  logic        ready1, done1, rd1, wr1;
  logic [31:0] rdata1, rdi1, rdo1;
  logic [8:0]  ra1;
  logic        ready3, done3, rd3, wr3;
  logic [31:0] rdata3, rdi3, rdo3;
  logic [8:0]  ra3;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1)) dut1 (
    .clk(clk), .clear(clear),
    .req_valid(valid1), .req_ready(ready1), .req_we(we), .req_addr(addr), .req_wdata(wdata),
    .resp_done(done1), .resp_rdata(rdata1),
    .ram_read(rd1), .ram_write(wr1), .ram_address(ra1), .ram_data_in(rdi1), .ram_data_out(rdo1)
  );

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LAT(3)) dut3 (
    .clk(clk), .clear(clear),
    .req_valid(valid3), .req_ready(ready3), .req_we(we), .req_addr(addr), .req_wdata(wdata),
    .resp_done(done3), .resp_rdata(rdata3),
    .ram_read(rd3), .ram_write(wr3), .ram_address(ra3), .ram_data_in(rdi3), .ram_data_out(rdo3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: output carries garbage outside the valid window so mistimed captures show up
  logic [31:0] mem1 [512];
  logic [31:0] q1;
  always @(posedge clk) begin
    if (wr1) mem1[ra1] <= rdi1;
    q1 <= rd1 ? mem1[ra1] : 32'hBAD0_BAD1;
  end
  assign rdo1 = q1;

  logic [31:0] mem3 [512];
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    if (wr3) mem3[ra3] <= rdi3;
    pipe3[0] <= rd3 ? mem3[ra3] : 32'hBAD0_BAD3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdo3 = pipe3[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One request to dut1 (and dut3 when u3); both must be idle. Watches 10 cycles after accept.
  task automatic do_op(input logic op_we, input logic [8:0] a, input logic [31:0] d,
                       input logic u3, input logic [31:0] er1, input logic [31:0] er3);
    int s1 = 0, s3 = 0, sc1 = 0, sc3 = 0, n1 = 0, n3 = 0, dc1 = 0, dc3 = 0, both = 0, kind1 = 0, kind3 = 0;
    logic [8:0]  sa1 = '0, sa3 = '0;
    logic [31:0] sd1 = '0, sd3 = '0;
    valid1 = 1'b1; valid3 = u3; we = op_we; addr = a; wdata = d;
    @(posedge clk); #1;
    valid1 = 1'b0; valid3 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    for (int k = 1; k <= 10; k++) begin
      if (rd1 || wr1) begin s1++; sc1 = k; sa1 = ra1; sd1 = rdi1; kind1 = wr1 ? 1 : 0; end
      if (rd3 || wr3) begin s3++; sc3 = k; sa3 = ra3; sd3 = rdi3; kind3 = wr3 ? 1 : 0; end
      if ((rd1 && wr1) || (rd3 && wr3)) both++;
      if (done1) begin n1++; dc1 = k; end
      if (done3) begin n3++; dc3 = k; end
      @(posedge clk); #1;
    end
    check_eq("op_both_strobes", both, 0);
    check_eq("op1_strobe_cnt", s1, 1);
    check_eq("op1_strobe_cyc", sc1, 1);
    check_eq("op1_strobe_kind", kind1, op_we ? 1 : 0);
    check_eq("op1_addr", {23'd0, sa1}, {23'd0, a});
    if (op_we) check_eq("op1_wdata", sd1, d);
    check_eq("op1_done_cnt", n1, 1);
    check_eq("op1_done_cyc", dc1, op_we ? 2 : 3);
    check_eq("op1_rdata", rdata1, er1);
    if (u3) begin
      check_eq("op3_strobe_cnt", s3, 1);
      check_eq("op3_strobe_cyc", sc3, 1);
      check_eq("op3_strobe_kind", kind3, op_we ? 1 : 0);
      check_eq("op3_addr", {23'd0, sa3}, {23'd0, a});
      if (op_we) check_eq("op3_wdata", sd3, d);
      check_eq("op3_done_cnt", n3, 1);
      check_eq("op3_done_cyc", dc3, op_we ? 2 : 5);
      check_eq("op3_rdata", rdata3, er3);
    end else begin
      check_eq("op3_idle_strobes", s3, 0);
      check_eq("op3_idle_done", n3, 0);
    end
  endtask

  initial begin
    logic [1:8] e_rdy, e_done, e_wr, e_rd;
    int spurious;
    clear = 1'b0; valid1 = 1'b0; valid3 = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // power-on reset
    @(posedge clk); #1;
    check_eq("rst_rdata1", rdata1, 32'h0);
    check_eq("rst_rdata3", rdata3, 32'h0);
    check_eq("rst_strobes", {28'd0, rd1, wr1, rd3, wr3}, 32'h0);
    check_eq("rst_done", {30'd0, done1, done3}, 32'h0);
    #2 clear = 1'b1;
    #1;
    check_eq("rst_ready", {30'd0, ready1, ready3}, 32'h3);
    @(posedge clk); #1;

    // write then read back
    do_op(1'b1, 9'h005, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h0);
    do_op(1'b0, 9'h005, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // boundary addresses
    do_op(1'b1, 9'h1FF, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_op(1'b1, 9'h000, 32'h0000_0001, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_op(1'b0, 9'h1FF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(1'b0, 9'h000, 32'h0, 1'b1, 32'h0000_0001, 32'h0000_0001);

    // reset while a write strobe is up
    valid1 = 1'b1; valid3 = 1'b1; we = 1'b1; addr = 9'h033; wdata = 32'h0000_0077;
    @(posedge clk); #1;
    valid1 = 1'b0; valid3 = 1'b0; we = 1'b0;
    check_eq("midrst_wr_before", {30'd0, wr1, wr3}, 32'h3);
    clear = 1'b0;
    #1;
    check_eq("midrst_wr_after", {28'd0, rd1, wr1, rd3, wr3}, 32'h0);
    check_eq("midrst_rdata1", rdata1, 32'h0);
    check_eq("midrst_rdata3", rdata3, 32'h0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;

    // back-to-back on dut1: write 0x010 then read 0x010 with valid held
    e_rdy  = 8'b00100011;
    e_done = 8'b01000100;
    e_wr   = 8'b10000000;
    e_rd   = 8'b00010000;
    valid1 = 1'b1; we = 1'b1; addr = 9'h010; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    we = 1'b0; wdata = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) valid1 = 1'b0;
      check_eq($sformatf("b2b_ready_c%0d", k), {31'd0, ready1}, {31'd0, e_rdy[k]});
      check_eq($sformatf("b2b_done_c%0d", k),  {31'd0, done1},  {31'd0, e_done[k]});
      check_eq($sformatf("b2b_wr_c%0d", k),    {31'd0, wr1},    {31'd0, e_wr[k]});
      check_eq($sformatf("b2b_rd_c%0d", k),    {31'd0, rd1},    {31'd0, e_rd[k]});
      if (k == 1 || k == 4) check_eq("b2b_addr", {23'd0, ra1}, 32'h010);
      @(posedge clk); #1;
    end
    check_eq("b2b_rdata", rdata1, 32'hA5A5_A5A5);
    do_op(1'b1, 9'h020, 32'h1111_2222, 1'b0, 32'hA5A5_A5A5, 32'h0);

    // READ_LAT=3 path
    do_op(1'b1, 9'h0AA, 32'h1234_5678, 1'b1, 32'hA5A5_A5A5, 32'h0);
    do_op(1'b0, 9'h0AA, 32'h0, 1'b1, 32'h1234_5678, 32'h1234_5678);

    // reset during a read (dut1 in CAPTURE, dut3 in WAIT)
    valid1 = 1'b1; valid3 = 1'b1; we = 1'b0; addr = 9'h0AA;
    @(posedge clk); #1;
    valid1 = 1'b0; valid3 = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    check_eq("rdrst_rdata1", rdata1, 32'h0);
    check_eq("rdrst_rdata3", rdata3, 32'h0);
    check_eq("rdrst_outs", {27'd0, rd1, wr1, rd3, wr3, done1 | done3}, 32'h0);
    @(posedge clk); #1;
    clear = 1'b1;
    #1;
    check_eq("rdrst_ready", {30'd0, ready1, ready3}, 32'h3);
    spurious = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done1 || done3 || rd1 || rd3 || wr1 || wr3) spurious++;
    end
    check_eq("rdrst_no_done", spurious, 0);
    do_op(1'b0, 9'h1FF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
